// File: rtl/uart_alu_pkg.sv
// Shared types and elaboration-time helpers for the UART-to-ALU frame sequencer.
package uart_alu_pkg;

   typedef enum logic [2:0] {
      RX_A  = 3'd0,
      RX_B  = 3'd1,
      RX_OP = 3'd2,
      EXEC  = 3'd3,
      SEND  = 3'd4,
      GUARD = 3'd5
   } state_t;

   function automatic int unsigned n_bytes_of(input int unsigned nb_operand,
                                              input int unsigned nb_byte);
      return nb_operand / nb_byte;
   endfunction

   // Counter must be able to hold N_BYTES itself (GUARD compares against it).
   function automatic int unsigned cnt_width(input int unsigned n_bytes);
      return $clog2(n_bytes + 1);
   endfunction

   function automatic bit params_ok(input int unsigned nb_byte,
                                    input int unsigned nb_operand,
                                    input int unsigned nb_ops);
      return (nb_byte > 0) && (nb_operand >= nb_byte) &&
             ((nb_operand % nb_byte) == 0) && (nb_ops > 0) && (nb_ops <= nb_byte);
   endfunction

   function automatic bit timer_ok(input int unsigned cycles,
                                   input int unsigned nb_timeout);
      return (cycles > 0) && (nb_timeout > 0) && ((cycles >> nb_timeout) == 0);
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and
// pulses o_expired on the TIMEOUT_CYCLES-th idle cycle.
module frame_timer
   import uart_alu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned NB_TIMEOUT     = 20
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam logic [NB_TIMEOUT-1:0] LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

   if (!timer_ok(TIMEOUT_CYCLES, NB_TIMEOUT)) begin : g_bad_timer_params
      $error("frame_timer: 2**NB_TIMEOUT must exceed TIMEOUT_CYCLES");
   end

   logic [NB_TIMEOUT-1:0] count;

   // A clear in the expiry cycle suppresses the pulse: the incoming byte wins.
   assign o_expired = i_enable && !i_clear && (count == LAST);

   always_ff @(posedge i_clk) begin
      if (!i_reset || i_clear || !i_enable || o_expired) begin
         count <= '0;
      end else begin
         count <= count + NB_TIMEOUT'(1);
      end
   end

endmodule

// File: rtl/uart_alu_sequencer.sv
// Assembles multi-byte A/B operands and an opcode from the UART RX stream,
// drives the ALU and returns the result LSB-first through UART TX.
module uart_alu_sequencer
   import uart_alu_pkg::*;
#(
   parameter int unsigned NB_BYTE        = 8,
   parameter int unsigned NB_OPERAND     = 16,
   parameter int unsigned NB_OPS         = 6,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned NB_TIMEOUT     = 20
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [NB_BYTE-1:0]    i_rx_data,
   input  logic                  i_rx_valid,
   input  logic                  i_tx_busy,
   input  logic [NB_OPERAND-1:0] i_res,
   output logic [NB_OPERAND-1:0] o_data_a,
   output logic [NB_OPERAND-1:0] o_data_b,
   output logic [NB_OPS-1:0]     o_ops,
   output logic [NB_BYTE-1:0]    o_tx_data,
   output logic                  o_tx_valid,
   output logic                  o_busy,
   output logic                  o_frame_err,
   output logic                  o_drop
);

   localparam int unsigned       N_BYTES  = n_bytes_of(NB_OPERAND, NB_BYTE);
   localparam int unsigned       NB_CNT   = cnt_width(N_BYTES);
   localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(N_BYTES - 1);
   localparam logic [NB_CNT-1:0] CNT_FULL = NB_CNT'(N_BYTES);

   if (!params_ok(NB_BYTE, NB_OPERAND, NB_OPS)) begin : g_bad_params
      $error("uart_alu_sequencer: illegal NB_BYTE/NB_OPERAND/NB_OPS combination");
   end

   state_t                state, state_next;
   logic [NB_CNT-1:0]     cnt, cnt_next;
   logic [NB_OPERAND-1:0] shadow_a, shadow_a_next, shadow_b, shadow_b_next;
   logic [NB_OPERAND-1:0] result, result_next;
   logic [NB_OPERAND-1:0] data_a_next, data_b_next;
   logic [NB_OPS-1:0]     ops_next;
   logic [NB_BYTE-1:0]    tx_data_next;
   logic                  tx_valid_next, frame_err_next, drop_next;
   logic                  frame_active, expired;

   assign frame_active = ((state == RX_A) && (cnt != '0)) || (state == RX_B) || (state == RX_OP);
   assign o_busy       = (state == EXEC) || (state == SEND) || (state == GUARD);

   frame_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .NB_TIMEOUT     (NB_TIMEOUT)
   ) u_frame_timer (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clear   (i_rx_valid),
      .i_enable  (frame_active),
      .o_expired (expired)
   );

   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      shadow_a_next  = shadow_a;
      shadow_b_next  = shadow_b;
      result_next    = result;
      data_a_next    = o_data_a;
      data_b_next    = o_data_b;
      ops_next       = o_ops;
      tx_data_next   = o_tx_data;
      tx_valid_next  = 1'b0;
      frame_err_next = 1'b0;
      drop_next      = 1'b0;

      case (state)
         RX_A, RX_B: begin
            if (i_rx_valid) begin
               for (int unsigned i = 0; i < N_BYTES; i++) begin
                  if (cnt == NB_CNT'(i)) begin
                     if (state == RX_A) shadow_a_next[i*NB_BYTE +: NB_BYTE] = i_rx_data;
                     else               shadow_b_next[i*NB_BYTE +: NB_BYTE] = i_rx_data;
                  end
               end
               if (cnt == CNT_LAST) begin
                  state_next = (state == RX_A) ? RX_B : RX_OP;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + NB_CNT'(1);
               end
            end
         end
         RX_OP: begin
            if (i_rx_valid) begin
               if ((i_rx_data >> NB_OPS) != '0) begin
                  frame_err_next = 1'b1;
                  state_next     = RX_A;
                  cnt_next       = '0;
               end else begin
                  data_a_next = shadow_a;
                  data_b_next = shadow_b;
                  ops_next    = i_rx_data[NB_OPS-1:0];
                  state_next  = EXEC;
               end
            end
         end
         EXEC: begin
            result_next = i_res;
            cnt_next    = '0;
            state_next  = SEND;
         end
         SEND: begin
            if (!i_tx_busy) begin
               tx_valid_next = 1'b1;
               tx_data_next  = result[NB_BYTE-1:0];
               result_next   = result >> NB_BYTE;
               cnt_next      = cnt + NB_CNT'(1);
               state_next    = GUARD;
            end
         end
         GUARD: begin
            if (cnt == CNT_FULL) begin
               state_next = RX_A;
               cnt_next   = '0;
            end else begin
               state_next = SEND;
            end
         end
         default: begin
            state_next = RX_A;
            cnt_next   = '0;
         end
      endcase

      if (o_busy && i_rx_valid) drop_next = 1'b1;

      // Only reachable with no byte this cycle; abandons the partial frame.
      if (expired) begin
         state_next     = RX_A;
         cnt_next       = '0;
         frame_err_next = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state       <= RX_A;
         cnt         <= '0;
         shadow_a    <= '0;
         shadow_b    <= '0;
         result      <= '0;
         o_data_a    <= '0;
         o_data_b    <= '0;
         o_ops       <= '0;
         o_tx_data   <= '0;
         o_tx_valid  <= 1'b0;
         o_frame_err <= 1'b0;
         o_drop      <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         shadow_a    <= shadow_a_next;
         shadow_b    <= shadow_b_next;
         result      <= result_next;
         o_data_a    <= data_a_next;
         o_data_b    <= data_b_next;
         o_ops       <= ops_next;
         o_tx_data   <= tx_data_next;
         o_tx_valid  <= tx_valid_next;
         o_frame_err <= frame_err_next;
         o_drop      <= drop_next;
      end
   end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Bench for uart_alu_sequencer: 16-bit operands, 50-cycle timeout, a tx model
// that stays busy 10 cycles per byte and a simple opcode-indexed ALU.
module tb_uart_alu_sequencer;

   localparam int unsigned TMO = 50;

   localparam logic [15:0] TA  [5] = '{16'h00F0, 16'h0F0F, 16'h1234, 16'h8000, 16'h0001};
   localparam logic [15:0] TB  [5] = '{16'h0FF0, 16'hF0F0, 16'h4321, 16'h8000, 16'h0001};
   localparam logic [7:0]  TOP [5] = '{8'h24, 8'h25, 8'h26, 8'h20, 8'h3F};

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        tx_busy;
   logic        hold_busy;
   logic [15:0] res;
   logic [15:0] data_a, data_b;
   logic [5:0]  ops;
   logic [7:0]  tx_data;
   logic        tx_valid, busy, frame_err, drop;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          err_seen = 0;
   int          drop_seen = 0;
   int          tx_cnt;
   bit          chk_en = 1'b0;
   logic [15:0] exp_a = '0, exp_b = '0;
   logic [5:0]  exp_ops = '0;
   logic [15:0] pend_a, pend_b;
   logic [7:0]  exp_tx [$];
   logic [7:0]  tx_log [$];

   always #5 clk = ~clk;

   uart_alu_sequencer #(
      .NB_BYTE        (8),
      .NB_OPERAND     (16),
      .NB_OPS         (6),
      .TIMEOUT_CYCLES (TMO),
      .NB_TIMEOUT     (20)
   ) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_rx_data   (rx_data),
      .i_rx_valid  (rx_valid),
      .i_tx_busy   (tx_busy),
      .i_res       (res),
      .o_data_a    (data_a),
      .o_data_b    (data_b),
      .o_ops       (ops),
      .o_tx_data   (tx_data),
      .o_tx_valid  (tx_valid),
      .o_busy      (busy),
      .o_frame_err (frame_err),
      .o_drop      (drop)
   );

   function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic [5:0] op);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         default: return '0;
      endcase
   endfunction

   assign res = alu_model(data_a, data_b, ops);

   // tx model: busy from the cycle after a valid, for 10 cycles
   always @(posedge clk) begin
      if (!rst)          tx_cnt <= 0;
      else if (tx_valid) tx_cnt <= 10;
      else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
   end
   assign tx_busy = hold_busy || (tx_cnt != 0);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the frame-level model
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("alu_a", 32'(data_a), 32'(exp_a));
         check("alu_b", 32'(data_b), 32'(exp_b));
         check("alu_ops", 32'(ops), 32'(exp_ops));
         if (tx_valid) begin
            tx_log.push_back(tx_data);
            check("tx_while_busy", 32'(busy), 1);
            check("tx_expected", (exp_tx.size() != 0) ? 1 : 0, 1);
            if (exp_tx.size() != 0) check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
         end
         if (frame_err) err_seen++;
         if (drop) drop_seen++;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_op(input logic [7:0] op);
      logic [15:0] r;
      @(negedge clk);
      rx_data  = op;
      rx_valid = 1'b1;
      if (op[7:6] == 2'b00) begin
         exp_a   = pend_a;
         exp_b   = pend_b;
         exp_ops = op[5:0];
         r = alu_model(pend_a, pend_b, op[5:0]);
         exp_tx.push_back(r[7:0]);
         exp_tx.push_back(r[15:8]);
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
      pend_a = a;
      pend_b = b;
      send_byte(a[7:0]);
      send_byte(a[15:8]);
      send_byte(b[7:0]);
      send_byte(b[15:8]);
      send_op(op);
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #2;
         if (exp_tx.size() == 0 && !busy) break;
      end
      check(name, (exp_tx.size() == 0 && !busy) ? 1 : 0, 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_a"}, 32'(data_a), 0);
      check({tag, "_b"}, 32'(data_b), 0);
      check({tag, "_ops"}, 32'(ops), 0);
      check({tag, "_txd"}, 32'(tx_data), 0);
      check({tag, "_txv"}, 32'(tx_valid), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_err"}, 32'(frame_err), 0);
      check({tag, "_drop"}, 32'(drop), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_k, err0, drop0, n_err;
      bool_dummy_init();
      rst = 1'b0; rx_data = '0; rx_valid = 1'b0; hold_busy = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      chk_en = 1'b1;
      rst    = 1'b1;

      // Basic ADD frame with latency and busy-release check
      tx_log.delete();
      send_frame(16'h1234, 16'h5678, 8'h20);
      @(posedge clk); #2;
      check("lat_exec_busy", 32'(busy), 1);
      check("lat_no_tx_yet", 32'(tx_valid), 0);
      @(posedge clk); #2;
      check("lat_first_tx", 32'(tx_valid), 1);
      for (int i = 0; i < 40; i++) begin
         if (tx_log.size() >= 2) break;
         @(posedge clk); #2;
      end
      @(posedge clk); #2;
      check("busy_after_guard", 32'(busy), 0);
      check("add_n_tx", tx_log.size(), 2);
      check("add_tx0", 32'(tx_log[0]), 32'h AC);
      check("add_tx1", 32'(tx_log[1]), 32'h68);
      check("add_a_lit", 32'(data_a), 32'h1234);
      check("add_b_lit", 32'(data_b), 32'h5678);
      check("add_ops_lit", 32'(ops), 32'h20);

      // Timeout after two bytes
      err0 = err_seen;
      first_k = 0;
      send_byte(8'h34);
      send_byte(8'h12);
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #2;
         if (frame_err && first_k == 0) first_k = k;
      end
      check("timeout_cycle", first_k, TMO);
      check("timeout_once", err_seen - err0, 1);
      tx_log.delete();
      send_frame(16'h0001, 16'h0002, 8'h20);
      wait_done("after_timeout_done");
      check("after_timeout_tx0", 32'(tx_log[0]), 32'h03);
      check("after_timeout_tx1", 32'(tx_log[1]), 32'h00);

      // Byte arriving exactly in the expiry cycle wins
      err0 = err_seen;
      tx_log.delete();
      pend_a = 16'h0005;
      pend_b = 16'h0009;
      send_byte(8'h05);
      repeat (TMO - 2) @(negedge clk);
      send_byte(8'h00);
      send_byte(8'h09);
      send_byte(8'h00);
      send_op(8'h20);
      wait_done("expiry_edge_done");
      check("expiry_edge_no_err", err_seen - err0, 0);
      check("expiry_edge_tx0", 32'(tx_log[0]), 32'h0E);
      check("expiry_edge_tx1", 32'(tx_log[1]), 32'h00);

      // Bad opcode: error, no tx, ALU outputs held
      err0 = err_seen;
      tx_log.delete();
      pend_a = 16'h1111;
      pend_b = 16'h2222;
      send_byte(8'h11); send_byte(8'h11); send_byte(8'h22); send_byte(8'h22);
      send_op(8'hE0);
      check("badop_err_pulse", 32'(frame_err), 1);
      repeat (20) @(negedge clk);
      n_err = err_seen - err0;
      check("badop_err_once", n_err, 1);
      check("badop_no_tx", tx_log.size(), 0);
      check("badop_a_held", 32'(data_a), 32'h0005);
      check("badop_b_held", 32'(data_b), 32'h0009);

      // tx held busy: no send until release, RX byte in SEND is dropped
      drop0 = drop_seen;
      tx_log.delete();
      hold_busy = 1'b1;
      send_frame(16'h1000, 16'h0001, 8'h22);
      repeat (5) @(negedge clk);
      send_byte(8'h99);
      check("drop_pulse", 32'(drop), 1);
      repeat (195) @(negedge clk);
      check("held_no_tx", tx_log.size(), 0);
      check("held_busy", 32'(busy), 1);
      hold_busy = 1'b0;
      @(posedge clk); #2;
      check("release_tx", 32'(tx_valid), 1);
      wait_done("held_done");
      check("drop_once", drop_seen - drop0, 1);
      check("held_tx0", 32'(tx_log[0]), 32'hFF);
      check("held_tx1", 32'(tx_log[1]), 32'h0F);

      // Reset mid-frame
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      @(negedge clk);
      rst = 1'b0;
      exp_a = '0; exp_b = '0; exp_ops = '0;
      @(negedge clk);
      rst = 1'b1;
      check_all_zero("midreset");
      tx_log.delete();
      send_frame(16'h0A0B, 16'h0102, 8'h20);
      wait_done("post_reset_done");
      check("post_reset_tx0", 32'(tx_log[0]), 32'h0D);
      check("post_reset_tx1", 32'(tx_log[1]), 32'h0B);

      // Assorted opcodes
      for (int t = 0; t < 5; t++) begin
         tx_log.delete();
         send_frame(TA[t], TB[t], TOP[t]);
         wait_done("table_done");
         check("table_n_tx", tx_log.size(), 2);
      end

      check("queue_drained", exp_tx.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   function automatic void bool_dummy_init();
      tx_log.delete();
      exp_tx.delete();
   endfunction

endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
- Parametrised successor to the single-byte UART-to-ALU interface.
- Assembles multi-byte operands A and B, then an opcode byte, from the UART RX byte stream. Drives the combinational ALU and returns the multi-byte result through UART TX under a busy handshake.
- Adds an inter-byte timeout with frame abort, opcode validation, and drop reporting for bytes received while a result is being sent.
- Sits between rx/tx and alu inside the top level; baud generator, rx, tx and alu are unchanged.

Parameters:
- NB_BYTE, 8, UART byte width.
- NB_OPERAND, 16, operand/result width; must be an integer multiple of NB_BYTE (N_BYTES = NB_OPERAND/NB_BYTE, minimum 1).
- NB_OPS, 6, ALU opcode width; must be ≤ NB_BYTE.
- TIMEOUT_CYCLES, 1000000, idle clock cycles allowed between bytes of one frame.
- NB_TIMEOUT, 20, timeout counter width; must satisfy 2^NB_TIMEOUT > TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-low reset
- i_rx_data  in  NB_BYTE  received byte
- i_rx_valid  in  1  one-cycle pulse; i_rx_data valid
- i_tx_busy  in  1  tx shifting; rises the cycle after it sees o_tx_valid
- i_res  in  NB_OPERAND  ALU result (combinational from o_data_a/o_data_b/o_ops)
- o_data_a  out  NB_OPERAND  operand A to ALU
- o_data_b  out  NB_OPERAND  operand B to ALU
- o_ops  out  NB_OPS  opcode to ALU
- o_tx_data  out  NB_BYTE  byte to tx
- o_tx_valid  out  1  one-cycle pulse; tx starts a byte
- o_busy  out  1  high in EXEC/SEND/GUARD
- o_frame_err  out  1  one-cycle pulse on timeout or bad opcode
- o_drop  out  1  one-cycle pulse when an RX byte is discarded

Behaviour:
- Reset (i_reset==0 at a rising edge):
  - All outputs go to 0, state goes to RX_A, byte counter and timer clear.
  - Takes effect from any state, including mid-frame or mid-send; the partial frame and pending result are discarded.
- Frame format: N_BYTES of A, then N_BYTES of B, then 1 opcode byte. A and B are sent LSB first.
- States:
  - RX_A: accept bytes into a shadow A register at byte index cnt. After the N_BYTES-th byte go to RX_B, cnt=0.
  - RX_B: same into shadow B. After the last byte go to RX_OP.
  - RX_OP: on a byte:
    - Bits above NB_OPS nonzero: pulse o_frame_err, go to RX_A; ALU outputs unchanged.
    - Otherwise: o_data_a, o_data_b and o_ops load atomically from the shadow registers and the byte; go to EXEC.
  - EXEC: one cycle. Capture i_res into the result shift register, cnt=0, go to SEND.
  - SEND:
    - If i_tx_busy==0: at the edge, o_tx_valid<=1, o_tx_data<=result[NB_BYTE-1:0], shift the result right by NB_BYTE, cnt++, go to GUARD.
    - Otherwise hold.
  - GUARD: one cycle, o_tx_valid high. At the edge, o_tx_valid<=0. If cnt==N_BYTES go to RX_A, else go to SEND.
- Latency: opcode byte valid in cycle T → new ALU outputs visible T+1 → first o_tx_valid in T+3, provided i_tx_busy is low in T+2.
- Timeout:
  - Active only in RX_A/RX_B/RX_OP once at least one byte of the current frame has been accepted.
  - Counts cycles without i_rx_valid. At TIMEOUT_CYCLES-1: pulse o_frame_err, go to RX_A, cnt=0; shadow registers are don't-care.
  - i_rx_valid in the same cycle as expiry: the byte wins, the counter clears, no error.
- i_rx_valid during EXEC/SEND/GUARD: the byte is discarded, o_drop pulses next cycle, state is unaffected.
- o_data_a/o_data_b/o_ops hold their last value until the next valid frame completes, so o_alu stays stable while the next frame is being received.

Decomposition:
- Package uart_alu_pkg:
  - State enum localparams: RX_A, RX_B, RX_OP, EXEC, SEND, GUARD (3-bit).
  - N_BYTES and the width of the byte counter, clog2(N_BYTES+1).
  - Parameter legality checks.
- Sub-module frame_timer (params TIMEOUT_CYCLES, NB_TIMEOUT):
  - Inputs i_clk, i_reset, i_clear, i_enable.
  - Output o_expired, a one-cycle pulse.
- Instantiated once inside uart_alu_sequencer.

Test Plan (NB_OPERAND=16, ADD opcode=6'b100000, tx model raises busy for 10 cycles after valid):
- Bytes 0x34,0x12,0x78,0x56,0x20 → o_data_a=0x1234, o_data_b=0x5678, o_ops=0x20 one cycle after the last byte; tx receives 0xAC then 0x68; o_busy falls after the second GUARD.
- Bytes 0x34,0x12, then idle TIMEOUT_CYCLES (set 50 in the bench) → o_frame_err pulses once at cycle 50 after the last byte. The next full frame 0x01,0x00,0x02,0x00,0x20 returns 0x03,0x00.
- Byte arriving exactly at the expiry cycle → no o_frame_err; the frame completes normally.
- Opcode byte 0xE0 → o_frame_err pulse, no o_tx_valid, o_data_a/o_data_b/o_ops keep their previous values.
- i_tx_busy held high 200 cycles after EXEC → no o_tx_valid until busy drops, then valid within 1 cycle. An RX byte injected during SEND → o_drop pulse; the result bytes are unchanged.
- i_reset low for 1 cycle after 3 bytes of a frame → all outputs 0. A fresh full frame afterwards processes correctly with no stale bytes.
